// File: rtl/dmem_wbuf.sv
// dmem_wbuf: data-memory responder with a FIFO store buffer that drains
// into a single-port word array, plus byte-granular load forwarding.
module dmem_wbuf #(
  parameter int AW       = 12,
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [3:0]  mem_wen,
  input  logic        mem_rd_req,
  input  logic [31:0] mem_rd_addr,
  output logic [31:0] mem_rd_data,
  output logic        hold_o,
  output logic        wb_empty_o
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

  logic [31:0] mem_q [2**AW];

  logic [WB_DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0] addr_q [WB_DEPTH];
  logic [AW-1:0] addr_d [WB_DEPTH];
  logic [31:0]   data_q [WB_DEPTH];
  logic [31:0]   data_d [WB_DEPTH];
  logic [3:0]    strb_q [WB_DEPTH];
  logic [3:0]    strb_d [WB_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] wr_idx, rd_idx;
  logic          st_req, full, enq, drain;
  logic [31:0]   fwd_word;
  logic          unused_addr_bits;

  assign wr_idx = mem_wr_addr[AW+1:2];
  assign rd_idx = mem_rd_addr[AW+1:2];
  assign unused_addr_bits = ^{mem_wr_addr[31:AW+2], mem_wr_addr[1:0],
                              mem_rd_addr[31:AW+2], mem_rd_addr[1:0]};

  // Full is judged on the start-of-cycle count, even if a drain frees a slot.
  assign st_req     = |mem_wen;
  assign full       = (count_q == FULL);
  assign enq        = st_req && !full;
  assign drain      = (count_q != '0) && !mem_rd_req;
  assign hold_o     = st_req && full;
  assign wb_empty_o = (count_q == '0);

  // Walk oldest to youngest so the youngest matching lane wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = head_q;
    fwd_word = mem_q[rd_idx];
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      for (int l = 0; l < 4; l++) begin
        if (vld_q[idx] && addr_q[idx] == rd_idx && strb_q[idx][l])
          fwd_word[8*l +: 8] = data_q[idx][8*l +: 8];
      end
    end
  end

  assign mem_rd_data = mem_rd_req ? fwd_word : '0;

  always_comb begin
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = wr_idx;
      data_d[tail_q] = mem_wr_data;
      strb_d[tail_q] = mem_wen;
      tail_d         = tail_q + PW'(1);
    end
    if (drain) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    unique case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Array is never reset; a reset edge suppresses the pending drain write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (drain) begin
      for (int l = 0; l < 4; l++) begin
        if (strb_q[head_q][l])
          mem_q[addr_q[head_q]][8*l +: 8] <= data_q[head_q][8*l +: 8];
      end
    end
  end

endmodule
